stopwatch_lap_ctrl: RTL and testbench

STOPWATCH_LAP_CTRL -- requirements
Module: stopwatch_lap_ctrl

---
 rtl/stopwatch_pkg.sv | 21 ++
 rtl/stopwatch_lap_ctrl_lap_fifo.sv | 73 +++++++
 rtl/stopwatch_lap_ctrl.sv | 106 ++++++++++
 tb/tb_stopwatch_lap_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types: status encodings, time field widths and the lap record.
package stopwatch_pkg;

    localparam int MIN_W = 8;
    localparam int SEC_W = 6;
    localparam int LAP_W = MIN_W + SEC_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } status_t;

    function automatic logic [LAP_W-1:0] pack_lap(
        input logic [MIN_W-1:0] m,
        input logic [SEC_W-1:0] s
    );
        return {m, s};
    endfunction

endpackage

// File: rtl/stopwatch_lap_ctrl_lap_fifo.sv
// Synchronous lap FIFO with flush, sticky overflow and a registered head word.
module lap_fifo #(
    parameter int W     = 14,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_n;
    logic [AW:0]   cnt_n;
    logic [W-1:0]  head_n;
    logic          full;
    logic          pop_ok;
    logic          push_ok;

    assign valid   = (count != '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop_ok  = pop && valid;
    assign push_ok = push && (!full || pop_ok);

    // The new word becomes the head when it lands where the read pointer goes.
    always_comb begin
        rd_ptr_n = rd_ptr + AW'(pop_ok);
        cnt_n    = count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        head_n   = '0;
        if (cnt_n != '0) begin
            if (push_ok && (rd_ptr_n == wr_ptr)) begin
                head_n = din;
            end else begin
                head_n = mem[rd_ptr_n];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
            ovf    <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_ok);
            rd_ptr <= rd_ptr_n;
            count  <= cnt_n;
            dout   <= head_n;
            if (push && !push_ok) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch control FSM, prescaler and lap capture.
// Lap buffer is present only when STOPWATCH_LAP_EN is defined.
module stopwatch_lap_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV  = 100000000,
    parameter int LAP_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           stop,
    input  logic                           reset,
    input  logic                           lap,
    input  logic [MIN_W-1:0]               minutes,
    input  logic [SEC_W-1:0]               seconds,
    output logic                           tick_en,
    output logic                           clr,
    output logic [1:0]                     status,
    output logic                           lap_valid,
    input  logic                           lap_ready,
    output logic [MIN_W-1:0]               lap_min,
    output logic [SEC_W-1:0]               lap_sec,
    output logic [$clog2(LAP_DEPTH):0]     lap_count,
    output logic                           lap_ovf
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    status_t       state;
    status_t       state_n;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_n;
    logic          tick_n;

    // Every running cycle consumes one prescaler count, including the stop cycle.
    always_comb begin
        state_n = state;
        presc_n = presc;
        if (state == ST_RUN) begin
            presc_n = (presc == PMAX) ? '0 : presc + PW'(1);
        end
        if (reset) begin
            state_n = ST_IDLE;
            presc_n = '0;
        end else if (stop && (state == ST_RUN)) begin
            state_n = ST_PAUSE;
        end else if (start && (state != ST_RUN)) begin
            state_n = ST_RUN;
        end
        tick_n = (state_n == ST_RUN) && (presc_n == PMAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            presc   <= '0;
            tick_en <= 1'b0;
            clr     <= 1'b0;
        end else begin
            state   <= state_n;
            presc   <= presc_n;
            tick_en <= tick_n;
            clr     <= reset;
        end
    end

    assign status = state;

`ifdef STOPWATCH_LAP_EN
    logic             push;
    logic [LAP_W-1:0] lap_data;

    assign push = lap && (state != ST_IDLE) && !reset;

    lap_fifo #(
        .W     (LAP_W),
        .DEPTH (LAP_DEPTH)
    ) u_lap_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (reset),
        .push  (push),
        .pop   (lap_ready),
        .din   (pack_lap(minutes, seconds)),
        .dout  (lap_data),
        .valid (lap_valid),
        .count (lap_count),
        .ovf   (lap_ovf)
    );

    assign lap_min = lap_data[LAP_W-1:SEC_W];
    assign lap_sec = lap_data[SEC_W-1:0];
`else
    logic unused_lap;

    assign unused_lap = ^{lap, lap_ready, minutes, seconds};
    assign lap_valid  = 1'b0;
    assign lap_count  = '0;
    assign lap_ovf    = 1'b0;
    assign lap_min    = '0;
    assign lap_sec    = '0;
`endif

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Directed bench for stopwatch_lap_ctrl with a per-cycle reference model.
module tb_stopwatch_lap_ctrl;

    localparam int TD = 4;
    localparam int LD = 4;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       reset = 1'b0;
    logic       lap = 1'b0;
    logic       lap_ready = 1'b0;
    logic [7:0] minutes = '0;
    logic [5:0] seconds = '0;
    logic       tick_en;
    logic       clr;
    logic [1:0] status;
    logic       lap_valid;
    logic [7:0] lap_min;
    logic [5:0] lap_sec;
    logic [2:0] lap_count;
    logic       lap_ovf;

    stopwatch_lap_ctrl #(
        .TICK_DIV  (TD),
        .LAP_DEPTH (LD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .reset     (reset),
        .lap       (lap),
        .minutes   (minutes),
        .seconds   (seconds),
        .tick_en   (tick_en),
        .clr       (clr),
        .status    (status),
        .lap_valid (lap_valid),
        .lap_ready (lap_ready),
        .lap_min   (lap_min),
        .lap_sec   (lap_sec),
        .lap_count (lap_count),
        .lap_ovf   (lap_ovf)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: status code, running cycles since last clear, pending clr, lap queue.
    int          m_status = 0;
    int          m_ran = 0;
    bit          m_clr = 1'b0;
    bit          m_ovf = 1'b0;
    logic [13:0] q[$];

    always @(negedge clk) begin : cmp
        logic [22:0] e;
        logic [22:0] g;
        logic [13:0] hd;
        logic        tk;
        hd = (q.size() != 0) ? q[0] : 14'd0;
        tk = (m_status == 1) && (((m_ran + 1) % TD) == 0);
        e = {2'(m_status), tk, m_clr, q.size() != 0,
             3'(q.size()), m_ovf, hd};
        g = {status, tick_en, clr, lap_valid,
             lap_count, lap_ovf, lap_min, lap_sec};
        n_vec++;
        if (g !== e) begin
            n_err++;
            $display("FAIL cycle t=%0t: dut=%h model=%h", $time, g, e);
        end
        if (rst) begin
            m_status = 0;
            m_ran = 0;
            m_clr = 1'b0;
            m_ovf = 1'b0;
            q.delete();
        end else if (reset) begin
            m_status = 0;
            m_ran = 0;
            m_clr = 1'b1;
            m_ovf = 1'b0;
            q.delete();
        end else begin
            m_clr = 1'b0;
            if (LAP_EN) begin
                if (q.size() != 0 && lap_ready) void'(q.pop_front());
                if (lap && m_status != 0) begin
                    if (q.size() < LD) q.push_back({minutes, seconds});
                    else m_ovf = 1'b1;
                end
            end
            if (m_status == 1) m_ran++;
            if (stop && m_status == 1) m_status = 2;
            else if (start && m_status != 1) m_status = 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int le(input int v);
        return LAP_EN ? v : 0;
    endfunction

    initial begin
        int cnt;
        int first;
        int k;
        step(3);
        chk("rst_status", status, 0);
        chk("rst_count", lap_count, 0);
        rst = 1'b0;
        step(2);
        chk("idle_status", status, 0);
        seconds = 6'd7; lap = 1'b1; step(1); lap = 1'b0;
        chk("idle_lap_ignored", lap_count, 0);

        start = 1'b1; step(1); start = 1'b0;
        chk("start_status", status, 1);
        cnt = 0; first = -1;
        for (int i = 0; i < 40; i++) begin
            if (tick_en) begin
                cnt++;
                if (first < 0) first = i;
            end
            step(1);
        end
        chk("first_tick", first, 3);
        chk("ticks_in_40", cnt, 10);

        k = 0;
        while (!tick_en && k < 8) begin step(1); k++; end
        chk("tick_seen", tick_en, 1);
        step(2); stop = 1'b1; step(1); stop = 1'b0;
        chk("pause_status", status, 2);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (tick_en) cnt++;
            step(1);
        end
        chk("paused_ticks", cnt, 0);
        start = 1'b1; step(1); start = 1'b0;
        chk("resume_t1", tick_en, 0);
        step(1);
        chk("resume_t2", tick_en, 1);

        start = 1'b1; stop = 1'b1; reset = 1'b1; step(1);
        start = 1'b0; stop = 1'b0; reset = 1'b0;
        chk("cmd_rst_status", status, 0);
        chk("clr_pulse", clr, 1);
        step(1);
        chk("clr_single", clr, 0);
        start = 1'b1; step(1); start = 1'b0;
        k = 0;
        while (!tick_en && k < 8) begin step(1); k++; end
        chk("presc_zeroed", k, 3);

        for (int i = 1; i <= 5; i++) begin
            seconds = 6'(i); lap = 1'b1; step(1); lap = 1'b0;
        end
        chk("five_laps_count", lap_count, le(4));
        chk("five_laps_ovf", lap_ovf, le(1));
        step(2);
        for (int i = 1; i <= 4; i++) begin
            chk("read_min", lap_min, 0);
            chk("read_sec", lap_sec, le(i));
            lap_ready = 1'b1; step(1); lap_ready = 1'b0;
        end
        chk("drained", lap_count, 0);
        chk("ovf_sticky", lap_ovf, le(1));

        reset = 1'b1; step(1); reset = 1'b0;
        chk("ovf_cleared", lap_ovf, 0);
        start = 1'b1; step(1); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seconds = 6'(10 + i); lap = 1'b1; step(1); lap = 1'b0;
        end
        chk("full_count", lap_count, le(4));
        seconds = 6'd14; lap = 1'b1; lap_ready = 1'b1; step(1);
        lap = 1'b0; lap_ready = 1'b0;
        chk("push_pop_count", lap_count, le(4));
        chk("push_pop_ovf", lap_ovf, 0);
        chk("push_pop_head", lap_sec, le(11));
        seconds = 6'd20; lap = 1'b1; reset = 1'b1; step(1);
        lap = 1'b0; reset = 1'b0;
        chk("lap_vs_reset", lap_count, 0);

        start = 1'b1; step(1); start = 1'b0;
        seconds = 6'd30; lap = 1'b1; step(1);
        seconds = 6'd31; step(1); lap = 1'b0;
        chk("two_laps", lap_count, le(2));
        step(1);
        rst = 1'b1; step(1);
        chk("hw_rst_status", status, 0);
        chk("hw_rst_outs", {tick_en, clr, lap_valid, lap_count,
                            lap_ovf, lap_min, lap_sec}, 0);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (clr) cnt++;
            step(1);
        end
        rst = 1'b0;
        step(2);
        chk("hw_rst_no_clr", cnt, 0);
        chk("hw_rst_idle", status, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

endmodule
